dbus_timer: RTL
===============

Name: dbus_timer

Overview:
- Memory-mapped general-purpose timer peripheral; responder end of the data bus.
- Receives the decoded access (type_dbus2peri_s plus a select line from the dbus address decoder) and returns read data and ack (type_peri2dbus_s).
- Provides a prescaled 32-bit up-counter with compare match, periodic/one-shot modes and a level interrupt toward the PLIC.

Parameters:
- PRESCALE_W, 16, width of the prescaler register and prescaler counter (1..32).
- COMPARE_RST, 32'hFFFF_FFFF, reset value of COMPARE.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- dbus2peri_i  input  type_dbus2peri_s  bus request; fields used: addr, w_data[31:0], sel_byte[3:0], req, w_en
- timer_sel_i  input  1  module select from the dbus address decoder
- timer2dbus_o  output  type_peri2dbus_s  response; fields r_data[31:0] and ack
- timer_irq_o  output  1  interrupt request, level

Behaviour:
- Clocking and reset: one clock, clk. rst is asynchronous and active-high.
- Access condition: access = timer_sel_i & dbus2peri_i.req. The register is selected by addr[4:2]; addr[1:0] is ignored.
- Register map (byte offsets):
  - 0x00 CTRL: [0] EN, [1] PERIODIC, [2] IRQ_EN; other bits read 0.
  - 0x04 PRESCALE: [PRESCALE_W-1:0].
  - 0x08 COUNT: 32-bit, read/write.
  - 0x0C COMPARE: 32-bit.
  - 0x10 STATUS: [0] MATCH, write-1-to-clear.
  - Offsets 0x14–0x1C: read 0, writes ignored.
- Byte writes: each sel_byte[i] gates bits [8i+7:8i]. A lane with sel_byte[i]=0 is left unchanged. For STATUS, only lane 0 matters.
- Handshake FSM, states IDLE and ACK:
  - IDLE: on access, perform the write (if w_en) or latch read data (if !w_en), then go to ACK.
  - ACK: ack=1 for exactly one cycle; r_data holds the latched value. Always return to IDLE next cycle.
  - Requests present in ACK are not sampled. A request still high in the following IDLE cycle is treated as a new access.
  - Latency: ack and r_data are valid 1 cycle after the accepted request. Maximum throughput is 1 access per 2 cycles.
  - r_data = 0 whenever ack=0, and also for write acks.
  - Read data reflects register values before any same-cycle tick update.
- Prescaler:
  - When EN=1, pre_cnt increments each cycle.
  - When pre_cnt == PRESCALE, pre_cnt goes to 0 and a one-cycle tick fires. PRESCALE=0 therefore ticks every cycle.
  - While EN=0, pre_cnt is held at 0.
  - Any write to PRESCALE, or any CTRL write, clears pre_cnt.
- Counter on tick:
  - If COUNT == COMPARE: MATCH is set. If PERIODIC=1, COUNT goes to 0. If PERIODIC=0, COUNT holds and EN is cleared by hardware.
  - Otherwise COUNT increments, wrapping 32'hFFFF_FFFF to 0 with no flag.
- Simultaneous events:
  - A bus write to COUNT in the same cycle as a tick: the write wins and the tick is lost.
  - A bus write to CTRL.EN in the same cycle as a one-shot hardware clear: the bus write wins.
  - A STATUS W1C in the same cycle as a MATCH set: the set wins.
- Interrupt: timer_irq_o = MATCH & IRQ_EN, combinational from registered state, glitch-free.
- Reset values:
  - FSM=IDLE, ack=0, r_data=0, timer_irq_o=0.
  - CTRL=0, PRESCALE=0, COUNT=0, COMPARE=COMPARE_RST, MATCH=0, pre_cnt=0.
- Reset mid-operation: an asynchronous rst during ACK drops ack immediately. A pending write that was already performed remains lost after the reset values apply.

Test Plan:
- Reset, then read every offset 0x00–0x1C: ack exactly 1 cycle after req. Data is 0, except 0x0C = 32'hFFFF_FFFF; 0x14–0x1C read 0.
- Write 32'hA5A5_A5A5 to COMPARE with sel_byte=4'b0100, then read: result 32'hFFA5_FFFF. Hold req high for 3 cycles: exactly 2 acks (cycles 2 and 4).
- PRESCALE=3, COMPARE=2, CTRL=3'b111 (periodic, irq): COUNT steps every 4 cycles as 0,1,2,0. MATCH and timer_irq_o rise on the tick where COUNT==2. W1C STATUS clears irq; irq reasserts after the next match.
- One-shot: CTRL=3'b001, COMPARE=5, PRESCALE=0. MATCH sets after 6 ticks; EN reads 0; COUNT holds 5.
- Wrap: COUNT=32'hFFFF_FFFE, COMPARE=3, PRESCALE=0, EN=1. COUNT goes FFFF_FFFF, 0, 1, with no MATCH before COUNT reaches 3.
- Collisions: write COUNT=32'h10 on a tick cycle -> next read is 32'h10. W1C STATUS on a match cycle -> MATCH stays 1. Assert rst during ACK -> ack drops asynchronously and all registers return to reset values.

Source files
------------

// File: rtl/dbus_timer.sv
// dbus_timer: memory-mapped prescaled 32-bit timer with compare match,
// periodic/one-shot modes and a level interrupt. Responder on the data bus.

package dbus_timer_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] w_data;
    logic [3:0]  sel_byte;
    logic        req;
    logic        w_en;
  } type_dbus2peri_s;

  typedef struct packed {
    logic [31:0] r_data;
    logic        ack;
  } type_peri2dbus_s;
endpackage

module dbus_timer
  import dbus_timer_pkg::*;
#(
  parameter int          PRESCALE_W  = 16,
  parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
  input  logic            clk,
  input  logic            rst,
  input  type_dbus2peri_s dbus2peri_i,
  input  logic            timer_sel_i,
  output type_peri2dbus_s timer2dbus_o,
  output logic            timer_irq_o
);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t                state_q;
  logic                  ack_q;
  logic [31:0]           r_data_q;

  logic [2:0]            ctrl_q, ctrl_d;          // [0] EN, [1] PERIODIC, [2] IRQ_EN
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           compare_q, compare_d;
  logic                  match_q, match_d;

  logic                  access, wr_en, rd_en;
  logic [2:0]            reg_idx;
  logic                  wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;
  logic                  tick, hit;
  logic [31:0]           rd_val;
  logic                  unused_addr_bits;

  // Replace only the byte lanes enabled by sel
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return merged;
  endfunction

  // Requests are only sampled while idle, so a held request yields one ack every two cycles
  assign access      = timer_sel_i & dbus2peri_i.req & (state_q == S_IDLE);
  assign wr_en       = access & dbus2peri_i.w_en;
  assign rd_en       = access & ~dbus2peri_i.w_en;
  assign reg_idx     = dbus2peri_i.addr[4:2];
  assign wr_ctrl     = wr_en && (reg_idx == 3'd0);
  assign wr_prescale = wr_en && (reg_idx == 3'd1);
  assign wr_count    = wr_en && (reg_idx == 3'd2);
  assign wr_compare  = wr_en && (reg_idx == 3'd3);
  assign wr_status   = wr_en && (reg_idx == 3'd4);

  assign unused_addr_bits = ^{dbus2peri_i.addr[31:5], dbus2peri_i.addr[1:0]};

  // Tick when the prescaler reaches its limit; hit is a tick landing on the compare value
  assign tick = ctrl_q[0] && (pre_cnt_q == prescale_q);
  assign hit  = tick && (count_q == compare_q);

  // Read mux uses the current registered values, before any tick update this cycle
  always_comb begin
    rd_val = '0;
    case (reg_idx)
      3'd0:    rd_val = {29'd0, ctrl_q};
      3'd1:    rd_val = 32'(prescale_q);
      3'd2:    rd_val = count_q;
      3'd3:    rd_val = compare_q;
      3'd4:    rd_val = {31'd0, match_q};
      default: rd_val = '0;
    endcase
  end

  // Next-state for timer registers; bus writes are applied after tick effects so they win
  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    count_d    = count_q;
    compare_d  = compare_q;
    match_d    = match_q;

    if (wr_status && dbus2peri_i.sel_byte[0] && dbus2peri_i.w_data[0]) begin
      match_d = 1'b0;
    end

    if (tick) begin
      if (hit) begin
        match_d = 1'b1;
        if (ctrl_q[1]) begin
          count_d = '0;
        end else begin
          ctrl_d[0] = 1'b0;
        end
      end else begin
        count_d = count_q + 32'd1;
      end
    end

    if (wr_ctrl && dbus2peri_i.sel_byte[0]) begin
      ctrl_d = dbus2peri_i.w_data[2:0];
    end
    if (wr_prescale) begin
      prescale_d = PRESCALE_W'(merge_bytes(32'(prescale_q), dbus2peri_i.w_data,
                                           dbus2peri_i.sel_byte));
    end
    if (wr_count) begin
      count_d = merge_bytes(count_q, dbus2peri_i.w_data, dbus2peri_i.sel_byte);
    end
    if (wr_compare) begin
      compare_d = merge_bytes(compare_q, dbus2peri_i.w_data, dbus2peri_i.sel_byte);
    end

    if (wr_ctrl || wr_prescale || !ctrl_q[0] || tick) begin
      pre_cnt_d = '0;
    end else begin
      pre_cnt_d = pre_cnt_q + 1'b1;
    end
  end

  // Register the timer state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      pre_cnt_q  <= '0;
      count_q    <= '0;
      compare_q  <= COMPARE_RST;
      match_q    <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      match_q    <= match_d;
    end
  end

  // Handshake FSM with registered ack and read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ack_q    <= 1'b0;
      r_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (access) begin
            state_q  <= S_ACK;
            ack_q    <= 1'b1;
            r_data_q <= rd_en ? rd_val : 32'd0;
          end else begin
            ack_q    <= 1'b0;
            r_data_q <= '0;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          ack_q    <= 1'b0;
          r_data_q <= '0;
        end
      endcase
    end
  end

  assign timer2dbus_o.ack    = ack_q;
  assign timer2dbus_o.r_data = r_data_q;
  assign timer_irq_o         = match_q & ctrl_q[2];

endmodule
